progcounter: RTL and testbench
==============================

# progcounter

Parametrised full program counter for the 6502 datapath, the successor to the low-byte-only counter. It holds both the low (PCL) and high (PCH) bytes and loads either byte from the ADL/ADH buses. It increments with automatic carry into PCH, jams the reset/NMI/IRQ vectors, and performs 6502-style relative branches with a one-cycle page-cross fix-up. It sits between the address buses, the internal data bus and the instruction sequencer.

## Interface
Parameters:
- LOW_W, 8, width of PCL and of adlin/adlout/dbout
- HIGH_W, 8, width of PCH and of adhin/adhout
- VEC_RESET, 16'hFFFC, value loaded by rst and by setreset
- VEC_NMI, 16'hFFFA, value loaded by setnmi
- VEC_IRQ, 16'hFFFE, value loaded by setirq

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- adlin  in  LOW_W  ADL bus value for PCL
- adhin  in  HIGH_W  ADH bus value for PCH
- adlwa / adhwa  in  1  write PCL / PCH from the bus
- inc  in  1  increment the full PC
- setreset / setnmi / setirq  in  1  load the corresponding vector
- branch  in  1  add `offset` (signed) to PC
- offset  in  LOW_W  two's-complement branch displacement
- adloa / adhoa  in  1  drive adlout / adhout
- dboa  in  1  drive dbout
- dbsel  in  1  0: dbout = PCL; 1: dbout = PCH (low LOW_W bits)
- adlout  out  LOW_W  PCL when adloa, else 0
- adhout  out  HIGH_W  PCH when adhoa, else 0
- dbout  out  LOW_W  selected byte when dboa, else 0
- pclc  out  1  registered carry-out of the PCL increment
- pagecross  out  1  registered; high for the fix-up cycle
- busy  out  1  high while in FIXUP

## Operation
- State machine: IDLE, FIXUP.
- Precedence within one edge is rst > setreset > setnmi > setirq > FIXUP completion > adlwa/adhwa > branch > inc.
  - adlwa and adhwa may fire together; both bytes load.
  - Any bus write suppresses inc and branch in that cycle.
- inc: PC <= PC + 1 over LOW_W+HIGH_W bits. The result wraps from all-ones to 0. pclc <= 1 iff PCL was all-ones, else pclc <= 0.
- Branch in IDLE:
  - PCL <= PCL + offset, truncated.
  - Page cross means an unsigned carry out of PCL with offset positive, or no borrow-complement carry with offset negative.
  - On a page cross: state <= FIXUP and pagecross <= 1.
  - Otherwise the state stays IDLE.
- FIXUP, exactly one cycle:
  - PCH <= PCH + 1 for a forward cross, PCH - 1 for a backward cross. PCH wraps modulo 2^HIGH_W.
  - state <= IDLE and pagecross <= 0.
  - inc, branch and bus writes presented during FIXUP are ignored.
  - rst or a vector load aborts FIXUP, goes to IDLE and clears pagecross.
- Vector loads set PC to the parameter value and clear pclc.
- Output muxes are combinational from the PC registers.

## Timing
- Reset values: PC = VEC_RESET, state IDLE, pclc 0, pagecross 0, busy 0. Output values follow their enables (adlout = 8'hFC only if adloa is high).
- All register updates occur on the rising clk edge. Outputs reflect a new PC in the same cycle after the edge, with zero added latency.
- Branch latency:
  - 1 edge with no page cross.
  - 2 edges with a cross. busy is high between the edges and the sequencer must hold further PC commands.
- pclc and pagecross are asserted for exactly one cycle per event.

## Configuration
- PC_BRANCH_EN defined: branch/offset logic, the FIXUP state, pagecross and busy are present as described.
- PC_BRANCH_EN undefined:
  - branch and offset are ignored.
  - pagecross and busy are tied 0 and the state machine is IDLE only.
  - inc, bus writes, vectors and outputs are unchanged.

## Test plan
- Reset:
  - Stimulus: rst=1 for one edge with adloa=adhoa=1.
  - Response: adlout=8'hFC, adhout=8'hFF, busy=0, pclc=0.
- Bus load and increment wrap:
  - Stimulus: adlwa=adhwa=1 with adlin=8'hFF, adhin=8'h12, then inc for one edge.
  - Response: PC=16'h1300, pclc=1 for one cycle. A further inc gives 16'h1301 with pclc=0.
- Forward branch with page cross:
  - Stimulus: PC=16'h12F0, branch with offset=8'h20.
  - Response: after edge 1, PCL=8'h10, busy=1, pagecross=1. After edge 2, PC=16'h1310 and busy=0.
- Backward branch, no cross then cross:
  - Stimulus: PC=16'h1250 with offset=8'hF0.
  - Response: 16'h1240 in 1 edge.
  - Stimulus: PC=16'h1205 with offset=8'hF0.
  - Response: 16'h11F5 after 2 edges.
- Precedence and abort:
  - Stimulus: setnmi during FIXUP.
  - Response: PC=16'hFFFA, busy=0.
  - Stimulus: setreset+setirq+inc together.
  - Response: PC=16'hFFFC.
  - Stimulus: adlwa+inc together.
  - Response: PCL=adlin with no increment.
- Output muxing:
  - Stimulus: PC=16'hABCD, dboa=1, dbsel toggled.
  - Response: dbout=8'hCD then 8'hAB. With dboa=0, dbout=0.

Source files
------------

// File: rtl/progcounter.sv
// Full 6502 program counter (PCL/PCH) with bus loads, increment, vector jams
// and, when PC_BRANCH_EN is defined, relative branches with a page-cross fix-up.
module progcounter #(
   parameter int LOW_W  = 8,
   parameter int HIGH_W = 8,
   parameter logic [LOW_W+HIGH_W-1:0] VEC_RESET = 16'hFFFC,
   parameter logic [LOW_W+HIGH_W-1:0] VEC_NMI   = 16'hFFFA,
   parameter logic [LOW_W+HIGH_W-1:0] VEC_IRQ   = 16'hFFFE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LOW_W-1:0]  adlin,
   input  logic [HIGH_W-1:0] adhin,
   input  logic              adlwa,
   input  logic              adhwa,
   input  logic              inc,
   input  logic              setreset,
   input  logic              setnmi,
   input  logic              setirq,
   input  logic              branch,
   input  logic [LOW_W-1:0]  offset,
   input  logic              adloa,
   input  logic              adhoa,
   input  logic              dboa,
   input  logic              dbsel,
   output logic [LOW_W-1:0]  adlout,
   output logic [HIGH_W-1:0] adhout,
   output logic [LOW_W-1:0]  dbout,
   output logic              pclc,
   output logic              pagecross,
   output logic              busy
);

   localparam int PW = LOW_W + HIGH_W;

   logic [LOW_W-1:0]  pcl, pcl_nx;
   logic [HIGH_W-1:0] pch, pch_nx;
   logic              pclc_nx;
   logic [PW-1:0]     pc_inc;
   logic [LOW_W-1:0]  pch_lo;

   assign pc_inc = {pch, pcl} + PW'(1);
   assign pch_lo = LOW_W'(pch);

`ifdef PC_BRANCH_EN
   typedef enum logic {IDLE, FIXUP} state_t;

   state_t          state, state_nx;
   logic            pagecross_r, pagecross_nx;
   logic            fwd, fwd_nx;
   logic [LOW_W:0]  bsum;
   logic            cross;

   // A positive offset crosses on carry-out; a negative one crosses when the
   // two's-complement add produces no carry.
   assign bsum  = {1'b0, pcl} + {1'b0, offset};
   assign cross = offset[LOW_W-1] ? ~bsum[LOW_W] : bsum[LOW_W];

   assign pagecross = pagecross_r;
   assign busy      = (state == FIXUP);
`else
   logic unused_branch;
   assign unused_branch = ^{branch, offset};
   assign pagecross     = 1'b0;
   assign busy          = 1'b0;
`endif

   always_comb begin
      pcl_nx  = pcl;
      pch_nx  = pch;
      pclc_nx = 1'b0;
`ifdef PC_BRANCH_EN
      state_nx     = IDLE;
      pagecross_nx = 1'b0;
      fwd_nx       = fwd;
`endif
      if (setreset) begin
         {pch_nx, pcl_nx} = VEC_RESET;
      end else if (setnmi) begin
         {pch_nx, pcl_nx} = VEC_NMI;
      end else if (setirq) begin
         {pch_nx, pcl_nx} = VEC_IRQ;
`ifdef PC_BRANCH_EN
      end else if (state == FIXUP) begin
         pch_nx = fwd ? pch + HIGH_W'(1) : pch - HIGH_W'(1);
`endif
      end else if (adlwa || adhwa) begin
         if (adlwa) pcl_nx = adlin;
         if (adhwa) pch_nx = adhin;
`ifdef PC_BRANCH_EN
      end else if (branch) begin
         pcl_nx = bsum[LOW_W-1:0];
         if (cross) begin
            state_nx     = FIXUP;
            pagecross_nx = 1'b1;
            fwd_nx       = ~offset[LOW_W-1];
         end
`endif
      end else if (inc) begin
         {pch_nx, pcl_nx} = pc_inc;
         pclc_nx          = &pcl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcl  <= VEC_RESET[LOW_W-1:0];
         pch  <= VEC_RESET[PW-1:LOW_W];
         pclc <= 1'b0;
`ifdef PC_BRANCH_EN
         state       <= IDLE;
         pagecross_r <= 1'b0;
         fwd         <= 1'b0;
`endif
      end else begin
         pcl  <= pcl_nx;
         pch  <= pch_nx;
         pclc <= pclc_nx;
`ifdef PC_BRANCH_EN
         state       <= state_nx;
         pagecross_r <= pagecross_nx;
         fwd         <= fwd_nx;
`endif
      end
   end

   assign adlout = adloa ? pcl : '0;
   assign adhout = adhoa ? pch : '0;
   assign dbout  = dboa ? (dbsel ? pch_lo : pcl) : '0;

endmodule

// File: tb/tb_progcounter.sv
// Self-checking bench for progcounter: directed vectors, a target-address
// model of the PC and a per-cycle output comparison.
module tb_progcounter;

`ifdef PC_BRANCH_EN
   localparam bit BR_EN = 1'b1;
`else
   localparam bit BR_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] adlin, adhin, offset;
   logic       adlwa, adhwa, inc, setreset, setnmi, setirq, branch;
   logic       adloa, adhoa, dboa, dbsel;
   logic [7:0] adlout, adhout, dbout;
   logic       pclc, pagecross, busy;

   int n_chk  = 0;
   int n_fail = 0;
   bit started = 1'b0;

   // Model state
   logic [15:0] m_pc;
   logic        m_pclc, m_busy;
   logic [7:0]  m_ptgt;

   progcounter #(
      .LOW_W(8), .HIGH_W(8),
      .VEC_RESET(16'hFFFC), .VEC_NMI(16'hFFFA), .VEC_IRQ(16'hFFFE)
   ) dut (
      .clk(clk), .rst(rst), .adlin(adlin), .adhin(adhin),
      .adlwa(adlwa), .adhwa(adhwa), .inc(inc),
      .setreset(setreset), .setnmi(setnmi), .setirq(setirq),
      .branch(branch), .offset(offset),
      .adloa(adloa), .adhoa(adhoa), .dboa(dboa), .dbsel(dbsel),
      .adlout(adlout), .adhout(adhout), .dbout(dbout),
      .pclc(pclc), .pagecross(pagecross), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] branch_target(logic [15:0] pc, logic [7:0] off);
      return pc + {{8{off[7]}}, off};
   endfunction

   // Behavioural model: a branch lands its low byte at once; if the full
   // 16-bit target lies on another page, its high byte arrives one edge later.
   always @(posedge clk) begin
      if (rst) begin
         m_pc <= 16'hFFFC; m_pclc <= 1'b0; m_busy <= 1'b0;
      end else if (setreset) begin
         m_pc <= 16'hFFFC; m_pclc <= 1'b0; m_busy <= 1'b0;
      end else if (setnmi) begin
         m_pc <= 16'hFFFA; m_pclc <= 1'b0; m_busy <= 1'b0;
      end else if (setirq) begin
         m_pc <= 16'hFFFE; m_pclc <= 1'b0; m_busy <= 1'b0;
      end else if (m_busy) begin
         m_pc[15:8] <= m_ptgt; m_pclc <= 1'b0; m_busy <= 1'b0;
      end else if (adlwa || adhwa) begin
         if (adlwa) m_pc[7:0]  <= adlin;
         if (adhwa) m_pc[15:8] <= adhin;
         m_pclc <= 1'b0;
      end else if (BR_EN && branch) begin
         m_pc[7:0] <= branch_target(m_pc, offset) & 16'h00FF;
         m_ptgt    <= branch_target(m_pc, offset) >> 8;
         m_busy    <= (branch_target(m_pc, offset) >> 8) != {8'h00, m_pc[15:8]};
         m_pclc    <= 1'b0;
      end else if (inc) begin
         m_pc   <= m_pc + 16'd1;
         m_pclc <= ((m_pc + 16'd1) >> 8) != {8'h00, m_pc[15:8]};
      end else begin
         m_pclc <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("cyc_adlout", {8'h00, adlout}, adloa ? {8'h00, m_pc[7:0]} : 16'h0);
         chk("cyc_adhout", {8'h00, adhout}, adhoa ? {8'h00, m_pc[15:8]} : 16'h0);
         chk("cyc_dbout", {8'h00, dbout},
             dboa ? {8'h00, (dbsel ? m_pc[15:8] : m_pc[7:0])} : 16'h0);
         chk("cyc_pclc", {15'h0, pclc}, {15'h0, m_pclc});
         chk("cyc_pagecross", {15'h0, pagecross}, {15'h0, m_busy});
         chk("cyc_busy", {15'h0, busy}, {15'h0, m_busy});
      end
   end

   task automatic clr();
      rst = 1'b0; adlwa = 1'b0; adhwa = 1'b0; inc = 1'b0;
      setreset = 1'b0; setnmi = 1'b0; setirq = 1'b0; branch = 1'b0;
      adlin = 8'h00; adhin = 8'h00; offset = 8'h00;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] a);
      clr();
      adlwa = 1'b1; adhwa = 1'b1; adlin = a[7:0]; adhin = a[15:8];
      tick();
      clr();
   endtask

   task automatic do_branch(input logic [7:0] off);
      clr();
      branch = 1'b1; offset = off;
      tick();
      clr();
   endtask

   initial begin
      clr();
      adloa = 1'b1; adhoa = 1'b1; dboa = 1'b0; dbsel = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      started = 1'b1;
      chk("rst_adlout", {8'h00, adlout}, 16'h00FC);
      chk("rst_adhout", {8'h00, adhout}, 16'h00FF);
      chk("rst_busy", {15'h0, busy}, 16'h0);
      chk("rst_pclc", {15'h0, pclc}, 16'h0);
      chk("rst_model", m_pc, 16'hFFFC);

      load(16'h12FF);
      chk("load_pc", {adhout, adlout}, 16'h12FF);
      inc = 1'b1; tick(); clr();
      chk("inc_wrap_pc", {adhout, adlout}, 16'h1300);
      chk("inc_wrap_pclc", {15'h0, pclc}, 16'h1);
      chk("inc_wrap_model", {m_pc[15:1], m_pclc}, 16'h1301);
      inc = 1'b1; tick(); clr();
      chk("inc2_pc", {adhout, adlout}, 16'h1301);
      chk("inc2_pclc", {15'h0, pclc}, 16'h0);

      // Forward cross; junk commands during the fix-up must be ignored
      load(16'h12F0);
      do_branch(8'h20);
      chk("fwd_e1_pcl", {8'h00, adlout}, BR_EN ? 16'h0010 : 16'h00F0);
      chk("fwd_e1_busy", {15'h0, busy}, {15'h0, BR_EN});
      chk("fwd_e1_pagecross", {15'h0, pagecross}, {15'h0, BR_EN});
      inc = 1'b1; adlwa = 1'b1; adlin = 8'h77; branch = 1'b1; offset = 8'h20;
      tick(); clr();
      chk("fwd_e2_pc", {adhout, adlout}, BR_EN ? 16'h1310 : 16'h1277);
      chk("fwd_e2_busy", {15'h0, busy}, 16'h0);
      chk("fwd_e2_model", m_pc, BR_EN ? 16'h1310 : 16'h1277);

      load(16'h1250);
      do_branch(8'hF0);
      chk("back_nocross_pc", {adhout, adlout}, BR_EN ? 16'h1240 : 16'h1250);
      chk("back_nocross_busy", {15'h0, busy}, 16'h0);

      load(16'h1205);
      do_branch(8'hF0);
      chk("back_cross_e1", {adhout, adlout}, BR_EN ? 16'h12F5 : 16'h1205);
      chk("back_cross_e1_busy", {15'h0, busy}, {15'h0, BR_EN});
      tick();
      chk("back_cross_e2", {adhout, adlout}, BR_EN ? 16'h11F5 : 16'h1205);
      chk("back_cross_model", m_pc, BR_EN ? 16'h11F5 : 16'h1205);

      load(16'h1210);
      do_branch(8'h7F);
      chk("fwd_nocross_pc", {adhout, adlout}, BR_EN ? 16'h128F : 16'h1210);
      chk("fwd_nocross_busy", {15'h0, busy}, 16'h0);

      load(16'h12F0);
      do_branch(8'h20);
      setnmi = 1'b1; tick(); clr();
      chk("nmi_abort_pc", {adhout, adlout}, 16'hFFFA);
      chk("nmi_abort_busy", {15'h0, busy}, 16'h0);
      tick();
      chk("nmi_abort_hold", {adhout, adlout}, 16'hFFFA);

      setreset = 1'b1; setirq = 1'b1; inc = 1'b1; tick(); clr();
      chk("vec_prec_pc", {adhout, adlout}, 16'hFFFC);
      chk("vec_prec_pclc", {15'h0, pclc}, 16'h0);

      load(16'h1234);
      adlwa = 1'b1; adlin = 8'h56; inc = 1'b1; tick(); clr();
      chk("write_over_inc", {adhout, adlout}, 16'h1256);

      load(16'hABCD);
      dboa = 1'b1; dbsel = 1'b0; #1;
      chk("dbout_pcl", {8'h00, dbout}, 16'h00CD);
      dbsel = 1'b1; #1;
      chk("dbout_pch", {8'h00, dbout}, 16'h00AB);
      dboa = 1'b0; #1;
      chk("dbout_off", {8'h00, dbout}, 16'h0000);
      adloa = 1'b0; adhoa = 1'b0; #1;
      chk("adout_off", {adhout, adlout}, 16'h0000);
      tick();
      adloa = 1'b1; adhoa = 1'b1; dbsel = 1'b0;

      load(16'hFFFF);
      inc = 1'b1; tick(); clr();
      chk("inc_full_wrap", {adhout, adlout}, 16'h0000);
      chk("inc_full_wrap_pclc", {15'h0, pclc}, 16'h1);
      tick();
      chk("pclc_one_cycle", {15'h0, pclc}, 16'h0);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
